// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: opcodes, instruction classes, immediate formats
// and the funct3/funct7 codes used to reject illegal encodings.
package rv32_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_BR_BAD0 = 3'b010;
    localparam logic [2:0] F3_BR_BAD1 = 3'b011;
    localparam logic [2:0] F3_LD_BAD0 = 3'b011;
    localparam logic [2:0] F3_LD_BAD1 = 3'b110;
    localparam logic [2:0] F3_LD_BAD2 = 3'b111;
    localparam logic [2:0] F3_ST_MAX  = 3'b010;

    typedef enum logic [3:0] {
        CLS_LUI     = 4'd0,
        CLS_AUIPC   = 4'd1,
        CLS_JAL     = 4'd2,
        CLS_JALR    = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_LOAD    = 4'd5,
        CLS_STORE   = 4'd6,
        CLS_OP_IMM  = 4'd7,
        CLS_OP      = 4'd8,
        CLS_FENCE   = 4'd9,
        CLS_SYSTEM  = 4'd10,
        CLS_ILLEGAL = 4'd11
    } instr_class_e;

    typedef enum logic [2:0] {
        FMT_I = 3'd0,
        FMT_S = 3'd1,
        FMT_B = 3'd2,
        FMT_U = 3'd3,
        FMT_J = 3'd4
    } imm_fmt_e;

    // Classes that never produce a register result, independent of the rd field.
    function automatic logic classWritesRd(instr_class_e cls);
        return !(cls inside {CLS_BRANCH, CLS_STORE, CLS_FENCE, CLS_ILLEGAL});
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-decode handshake, regfile read addresses and decoded bundle towards execute.
interface decode_stage_if
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) ();

    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [XLEN-1:0]   in_pc;
    logic              flush;
    logic [4:0]        rf_read_addr1;
    logic [4:0]        rf_read_addr2;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    instr_class_e      out_class;
    logic [2:0]        out_funct3;
    logic              out_funct7b5;
    logic [4:0]        out_rd;
    logic [XLEN-1:0]   out_imm;
    logic              out_writes_rd;
    logic              out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, rf_read_addr1, rf_read_addr2, out_valid, out_pc, out_class,
               out_funct3, out_funct7b5, out_rd, out_imm, out_writes_rd, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, rf_read_addr1, rf_read_addr2, out_valid, out_pc, out_class,
               out_funct3, out_funct7b5, out_rd, out_imm, out_writes_rd, out_illegal
    );

endinterface

// File: rtl/rv32_imm_gen.sv
// Combinational RV32I immediate extraction; every format sign-extends from instr[31].
module rv32_imm_gen
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     i_instr,
    input  imm_fmt_e        i_fmt,
    output logic [XLEN-1:0] o_imm
);

    always_comb begin
        o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
        case (i_fmt)
            FMT_S: o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            FMT_B: o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                            i_instr[11:8], 1'b0};
            FMT_U: o_imm = {i_instr[31:12], 12'b0};
            FMT_J: o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                            i_instr[30:21], 1'b0};
            default: o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes the incoming word, steers regfile read addresses and holds
// one decoded bundle that lines up with the regfile's registered read data.
module decode_stage
    import rv32_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           rst,
    decode_stage_if.slave  bus
);

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [4:0]      w_rdField;
    instr_class_e    w_class;
    imm_fmt_e        w_fmt;
    logic            w_useRs1;
    logic            w_useRs2;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic            w_writesRd;
    logic [XLEN-1:0] w_imm;
    logic            w_inReady;
    logic            w_accept;

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    instr_class_e    r_class;
    logic [2:0]      r_funct3;
    logic            r_funct7b5;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_imm;
    logic            r_writesRd;
    logic            r_illegal;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;

    assign w_opcode  = bus.in_instr[6:0];
    assign w_funct3  = bus.in_instr[14:12];
    assign w_funct7  = bus.in_instr[31:25];
    assign w_rdField = bus.in_instr[11:7];

    // Anything that fails a field check falls through to the ILLEGAL default.
    always_comb begin
        w_class  = CLS_ILLEGAL;
        w_fmt    = FMT_I;
        w_useRs1 = 1'b0;
        w_useRs2 = 1'b0;
        if (bus.in_instr[1:0] == 2'b11) begin
            case (w_opcode)
                OPC_LUI: begin
                    w_class = CLS_LUI;
                    w_fmt   = FMT_U;
                end
                OPC_AUIPC: begin
                    w_class = CLS_AUIPC;
                    w_fmt   = FMT_U;
                end
                OPC_JAL: begin
                    w_class = CLS_JAL;
                    w_fmt   = FMT_J;
                end
                OPC_JALR: begin
                    if (w_funct3 == F3_ADD_SUB) begin
                        w_class  = CLS_JALR;
                        w_useRs1 = 1'b1;
                    end
                end
                OPC_BRANCH: begin
                    if (w_funct3 != F3_BR_BAD0 && w_funct3 != F3_BR_BAD1) begin
                        w_class  = CLS_BRANCH;
                        w_fmt    = FMT_B;
                        w_useRs1 = 1'b1;
                        w_useRs2 = 1'b1;
                    end
                end
                OPC_LOAD: begin
                    if (!(w_funct3 inside {F3_LD_BAD0, F3_LD_BAD1, F3_LD_BAD2})) begin
                        w_class  = CLS_LOAD;
                        w_useRs1 = 1'b1;
                    end
                end
                OPC_STORE: begin
                    if (w_funct3 <= F3_ST_MAX) begin
                        w_class  = CLS_STORE;
                        w_fmt    = FMT_S;
                        w_useRs1 = 1'b1;
                        w_useRs2 = 1'b1;
                    end
                end
                OPC_OP_IMM: begin
                    if (!((w_funct3 == F3_SLL && w_funct7 != F7_BASE) ||
                          (w_funct3 == F3_SRL_SRA && w_funct7 != F7_BASE && w_funct7 != F7_ALT))) begin
                        w_class  = CLS_OP_IMM;
                        w_useRs1 = 1'b1;
                    end
                end
                OPC_OP: begin
                    if (w_funct7 == F7_BASE ||
                        (w_funct7 == F7_ALT && (w_funct3 == F3_ADD_SUB || w_funct3 == F3_SRL_SRA))) begin
                        w_class  = CLS_OP;
                        w_useRs1 = 1'b1;
                        w_useRs2 = 1'b1;
                    end
                end
                OPC_FENCE: begin
                    w_class  = CLS_FENCE;
                    w_useRs1 = 1'b1;
                end
                OPC_SYSTEM: begin
                    w_class  = CLS_SYSTEM;
                    w_useRs1 = 1'b1;
                end
                default: w_class = CLS_ILLEGAL;
            endcase
        end
    end

    assign w_rs1      = w_useRs1 ? bus.in_instr[19:15] : 5'd0;
    assign w_rs2      = w_useRs2 ? bus.in_instr[24:20] : 5'd0;
    assign w_writesRd = classWritesRd(w_class) && (w_rdField != 5'd0);

    rv32_imm_gen #(.XLEN(XLEN)) u_immGen (
        .i_instr (bus.in_instr[31:7]),
        .i_fmt   (w_fmt),
        .o_imm   (w_imm)
    );

    assign w_inReady = !bus.flush && (!r_valid || bus.out_ready);
    assign w_accept  = bus.in_valid && w_inReady;

    // Regfile reads on every edge, so a held bundle keeps re-reading its own sources.
    assign bus.rf_read_addr1 = w_accept ? w_rs1 : r_rs1;
    assign bus.rf_read_addr2 = w_accept ? w_rs2 : r_rs2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_pc       <= RESET_PC;
            r_class    <= CLS_LUI;
            r_funct3   <= 3'd0;
            r_funct7b5 <= 1'b0;
            r_rd       <= 5'd0;
            r_imm      <= '0;
            r_writesRd <= 1'b0;
            r_illegal  <= 1'b0;
            r_rs1      <= 5'd0;
            r_rs2      <= 5'd0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid    <= 1'b1;
            r_pc       <= bus.in_pc;
            r_class    <= w_class;
            r_funct3   <= w_funct3;
            r_funct7b5 <= bus.in_instr[30];
            r_rd       <= w_writesRd ? w_rdField : 5'd0;
            r_imm      <= w_imm;
            r_writesRd <= w_writesRd;
            r_illegal  <= (w_class == CLS_ILLEGAL);
            r_rs1      <= w_rs1;
            r_rs2      <= w_rs2;
        end else if (r_valid && bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.in_ready      = w_inReady;
    assign bus.out_valid     = r_valid;
    assign bus.out_pc        = r_pc;
    assign bus.out_class     = r_class;
    assign bus.out_funct3    = r_funct3;
    assign bus.out_funct7b5  = r_funct7b5;
    assign bus.out_rd        = r_rd;
    assign bus.out_imm       = r_imm;
    assign bus.out_writes_rd = r_writesRd;
    assign bus.out_illegal   = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with a small synchronous regfile model on the read ports.
module tb_decode_stage;
    import rv32_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [3:0]  cls;
        logic [2:0]  f3;
        logic        f7b5;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        chkImm;
        logic        wr;
        logic        ill;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        rfWe;
    logic [4:0]  rfWa;
    logic [31:0] rfWd;
    logic [31:0] regs [32];
    logic [31:0] dataOut1;
    logic [31:0] dataOut2;
    int          checkCount;
    int          errorCount;
    vec_t        vecs [10];

    decode_stage_if #(.XLEN(32)) bus ();

    decode_stage #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Regfile model: registered reads of the pre-write contents, written on the same edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'h1000_0000 + i;
            dataOut1 <= 32'h0;
            dataOut2 <= 32'h0;
        end else begin
            if (rfWe) regs[rfWa] <= rfWd;
            dataOut1 <= regs[bus.rf_read_addr1];
            dataOut2 <= regs[bus.rf_read_addr2];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                                 input logic rdy, input logic fl);
        bus.in_valid  = v;
        bus.in_instr  = instr;
        bus.in_pc     = pc;
        bus.out_ready = rdy;
        bus.flush     = fl;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        checkCount = 0;
        errorCount = 0;
        rfWe = 1'b0;
        rfWa = 5'd0;
        rfWd = 32'h0;
        vecs[0] = '{32'hFFF08293, 32'h1000, 5'd1, 5'd0, CLS_OP_IMM,  3'd0, 1'b1, 5'd5, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{32'h0021A423, 32'h1004, 5'd3, 5'd2, CLS_STORE,   3'd2, 1'b0, 5'd0, 32'h00000008, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'h123453B7, 32'h1008, 5'd0, 5'd0, CLS_LUI,     3'd5, 1'b0, 5'd7, 32'h12345000, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{32'h00000000, 32'h100C, 5'd0, 5'd0, CLS_ILLEGAL, 3'd0, 1'b0, 5'd0, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{32'h402081B3, 32'h1010, 5'd1, 5'd2, CLS_OP,      3'd0, 1'b1, 5'd3, 32'h00000402, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{32'h4020C1B3, 32'h1014, 5'd0, 5'd0, CLS_ILLEGAL, 3'd4, 1'b1, 5'd0, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{32'h00208463, 32'h1018, 5'd1, 5'd2, CLS_BRANCH,  3'd0, 1'b0, 5'd0, 32'h00000008, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{32'hFFDFF0EF, 32'h101C, 5'd0, 5'd0, CLS_JAL,     3'd7, 1'b1, 5'd1, 32'hFFFFFFFC, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{32'h40109093, 32'h1020, 5'd0, 5'd0, CLS_ILLEGAL, 3'd1, 1'b1, 5'd0, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[9] = '{32'h4010D093, 32'h1024, 5'd1, 5'd0, CLS_OP_IMM,  3'd5, 1'b1, 5'd1, 32'h00000401, 1'b1, 1'b1, 1'b0};

        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset out_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("reset out_pc", bus.out_pc, RESET_PC);
        checkOutput("reset out_class", {28'b0, bus.out_class}, 32'd0);
        checkOutput("reset out_imm", bus.out_imm, 32'd0);
        checkOutput("reset out_rd", {27'b0, bus.out_rd}, 32'd0);
        checkOutput("reset in_ready", {31'b0, bus.in_ready}, 32'd1);
        rst = 1'b0;

        // Single instructions: addresses in the accept cycle, bundle and operands one edge later.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            applyStimulus(1'b1, vecs[k].instr, vecs[k].pc, 1'b1, 1'b0);
            #1;
            checkOutput($sformatf("v%0d rf_addr1", k), {27'b0, bus.rf_read_addr1}, {27'b0, vecs[k].a1});
            checkOutput($sformatf("v%0d rf_addr2", k), {27'b0, bus.rf_read_addr2}, {27'b0, vecs[k].a2});
            checkOutput($sformatf("v%0d in_ready", k), {31'b0, bus.in_ready}, 32'd1);
            @(negedge clk);
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            checkOutput($sformatf("v%0d out_valid", k), {31'b0, bus.out_valid}, 32'd1);
            checkOutput($sformatf("v%0d out_pc", k), bus.out_pc, vecs[k].pc);
            checkOutput($sformatf("v%0d out_class", k), {28'b0, bus.out_class}, {28'b0, vecs[k].cls});
            checkOutput($sformatf("v%0d out_funct3", k), {29'b0, bus.out_funct3}, {29'b0, vecs[k].f3});
            checkOutput($sformatf("v%0d out_funct7b5", k), {31'b0, bus.out_funct7b5}, {31'b0, vecs[k].f7b5});
            checkOutput($sformatf("v%0d out_rd", k), {27'b0, bus.out_rd}, {27'b0, vecs[k].rd});
            if (vecs[k].chkImm)
                checkOutput($sformatf("v%0d out_imm", k), bus.out_imm, vecs[k].imm);
            checkOutput($sformatf("v%0d out_writes_rd", k), {31'b0, bus.out_writes_rd}, {31'b0, vecs[k].wr});
            checkOutput($sformatf("v%0d out_illegal", k), {31'b0, bus.out_illegal}, {31'b0, vecs[k].ill});
            checkOutput($sformatf("v%0d data_out1", k), dataOut1, 32'h1000_0000 + vecs[k].a1);
            checkOutput($sformatf("v%0d data_out2", k), dataOut2, 32'h1000_0000 + vecs[k].a2);
        end
        @(negedge clk);
        checkOutput("drain out_valid", {31'b0, bus.out_valid}, 32'd0);

        // Stall: bundle held three cycles while rs1 is rewritten underneath it.
        applyStimulus(1'b1, 32'hFFF08293, 32'h2000, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 32'h123453B7, 32'h2004, 1'b0, 1'b0);
        #1;
        checkOutput("stall in_ready", {31'b0, bus.in_ready}, 32'd0);
        checkOutput("stall rf_addr1", {27'b0, bus.rf_read_addr1}, 32'd1);
        checkOutput("stall data_out1 old", dataOut1, 32'h1000_0001);
        rfWe = 1'b1;
        rfWa = 5'd1;
        rfWd = 32'hDEADBEEF;
        @(negedge clk);
        rfWe = 1'b0;
        checkOutput("stall c2 out_valid", {31'b0, bus.out_valid}, 32'd1);
        checkOutput("stall c2 out_pc", bus.out_pc, 32'h2000);
        checkOutput("stall c2 data_out1", dataOut1, 32'h1000_0001);
        @(negedge clk);
        checkOutput("stall c3 data_out1 new", dataOut1, 32'hDEADBEEF);
        checkOutput("stall c3 out_pc", bus.out_pc, 32'h2000);
        checkOutput("stall c3 out_rd", {27'b0, bus.out_rd}, 32'd5);
        checkOutput("stall c3 out_imm", bus.out_imm, 32'hFFFFFFFF);
        checkOutput("stall c3 in_ready", {31'b0, bus.in_ready}, 32'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("consume out_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("consume out_pc hold", bus.out_pc, 32'h2000);

        // Flush kills the held bundle and blocks the incoming one.
        applyStimulus(1'b1, 32'h402081B3, 32'h4000, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("flush held valid", {31'b0, bus.out_valid}, 32'd1);
        applyStimulus(1'b1, 32'h00208463, 32'h4004, 1'b0, 1'b1);
        #1;
        checkOutput("flush in_ready", {31'b0, bus.in_ready}, 32'd0);
        @(negedge clk);
        checkOutput("flush out_valid", {31'b0, bus.out_valid}, 32'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("flush no issue", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("flush pc not loaded", bus.out_pc, 32'h4000);

        // Back-to-back stream of addi x(k+1), x0, k+1.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k > 0) begin
                checkOutput($sformatf("stream%0d out_valid", k - 1), {31'b0, bus.out_valid}, 32'd1);
                checkOutput($sformatf("stream%0d out_pc", k - 1), bus.out_pc, 32'h3000 + 32'(4 * (k - 1)));
                checkOutput($sformatf("stream%0d out_rd", k - 1), {27'b0, bus.out_rd}, 32'(k));
                checkOutput($sformatf("stream%0d out_imm", k - 1), bus.out_imm, 32'(k));
            end
            if (k < 4) begin
                applyStimulus(1'b1, (32'(k + 1) << 20) | (32'(k + 1) << 7) | 32'h13,
                              32'h3000 + 32'(4 * k), 1'b1, 1'b0);
                #1;
                checkOutput($sformatf("stream%0d in_ready", k), {31'b0, bus.in_ready}, 32'd1);
            end else begin
                applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            end
        end
        @(negedge clk);
        checkOutput("stream drain", {31'b0, bus.out_valid}, 32'd0);

        // Asynchronous reset in the middle of a stall.
        applyStimulus(1'b1, 32'hFFF08293, 32'h5000, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("prereset valid", {31'b0, bus.out_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midstall rst valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("midstall rst pc", bus.out_pc, RESET_PC);
        checkOutput("midstall rst rd", {27'b0, bus.out_rd}, 32'd0);
        checkOutput("midstall rst imm", bus.out_imm, 32'd0);
        checkOutput("midstall rst writes_rd", {31'b0, bus.out_writes_rd}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
